gpr_busy_table: RTL and testbench

//  Per-architectural-GPR rename status table: busy bit + producing ROB number for r1..r31.

---
 rtl/gpr_busy_table_pkg.sv | 26 ++
 rtl/gpr_busy_table_if.sv | 35 +++
 rtl/gpr_busy_table_rdport.sv | 36 +++
 rtl/gpr_busy_table.sv | 73 +++++++
 tb/tb_gpr_busy_table.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/gpr_busy_table_pkg.sv
// Shared sizing for the GPR rename status table, plus the address-match helper
// used by both the entry update logic and the read ports.
package gpr_busy_table_pkg;

  localparam int GBT_ROB_SIZE = 32;
  localparam int GBT_RW       = $clog2(GBT_ROB_SIZE);
  localparam int GBT_NREG     = 32;
  localparam int GBT_AW       = 5;
  localparam int GBT_NRD      = 4;
  localparam int GBT_NWR      = 2;

  typedef enum logic [1:0] {
    RD_RS0 = 2'd0,
    RD_RT0 = 2'd1,
    RD_RS1 = 2'd2,
    RD_RT1 = 2'd3
  } rd_port_e;

  // r0 is never tracked, so a port aimed at it never matches anything.
  function automatic logic addr_hit(input logic en,
                                    input logic [GBT_AW-1:0] a,
                                    input logic [GBT_AW-1:0] b);
    return en && (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/gpr_busy_table_if.sv
// Rename/commit-side bundle for the GPR busy table: 4 read ports, 2 rename
// writes, 2 commit clears, flush and the debug busy vector.
interface gpr_busy_table_if
  import gpr_busy_table_pkg::*;
#(
  parameter int RW   = GBT_RW,
  parameter int NREG = GBT_NREG
);

  logic [GBT_NRD-1:0][GBT_AW-1:0] raddr;
  logic [GBT_NRD-1:0]             rbusy;
  logic [GBT_NRD-1:0][RW-1:0]     rnum;

  logic [GBT_NWR-1:0]             wen;
  logic [GBT_NWR-1:0][GBT_AW-1:0] waddr;
  logic [GBT_NWR-1:0][RW-1:0]     wnum;

  logic [GBT_NWR-1:0]             cmt_en;
  logic [GBT_NWR-1:0][GBT_AW-1:0] cmt_addr;
  logic [GBT_NWR-1:0][RW-1:0]     cmt_num;

  logic                           flush;
  logic [NREG-1:0]                busy_vec;

  modport master (
    output raddr, wen, waddr, wnum, cmt_en, cmt_addr, cmt_num, flush,
    input  rbusy, rnum, busy_vec
  );

  modport slave (
    input  raddr, wen, waddr, wnum, cmt_en, cmt_addr, cmt_num, flush,
    output rbusy, rnum, busy_vec
  );

endinterface

// File: rtl/gpr_busy_table_rdport.sv
// One combinational read port of the busy table. A producer retiring this
// cycle is bypassed to not-busy, since the ARF read already sees its value.
module gpr_busy_rdport
  import gpr_busy_table_pkg::*;
#(
  parameter int NREG = GBT_NREG,
  parameter int RW   = GBT_RW
) (
  input  logic [GBT_AW-1:0]             raddr_i,
  input  logic [NREG-1:0]               busy_i,
  input  logic [NREG-1:0][RW-1:0]       num_i,
  input  logic [GBT_NWR-1:0]            cmt_en_i,
  input  logic [GBT_NWR-1:0][GBT_AW-1:0] cmt_addr_i,
  input  logic [GBT_NWR-1:0][RW-1:0]    cmt_num_i,
  output logic                          rbusy_o,
  output logic [RW-1:0]                 rnum_o
);

  logic [RW-1:0] num_sel;
  logic          busy_sel;
  logic          retiring;
  logic          nonzero;

  assign nonzero  = (raddr_i != '0);
  assign num_sel  = num_i[raddr_i];
  assign busy_sel = busy_i[raddr_i];

  // Only the recorded producer counts; an older retiring writer of the same
  // register must not hide a younger pending one.
  assign retiring = (addr_hit(cmt_en_i[0], cmt_addr_i[0], raddr_i) && (cmt_num_i[0] == num_sel))
                 || (addr_hit(cmt_en_i[1], cmt_addr_i[1], raddr_i) && (cmt_num_i[1] == num_sel));

  assign rbusy_o = nonzero & busy_sel & ~retiring;
  assign rnum_o  = nonzero ? num_sel : '0;

endmodule

// File: rtl/gpr_busy_table.sv
// Per-GPR rename status: busy bit and producing ROB number for r1..r31,
// set by rename, cleared by the matching commit or by a flush.
module gpr_busy_table
  import gpr_busy_table_pkg::*;
#(
  parameter  int ROB_SIZE = GBT_ROB_SIZE,
  parameter  int NREG     = GBT_NREG,
  localparam int RW       = $clog2(ROB_SIZE)
) (
  input  logic             clk,
  input  logic             resetn,
  gpr_busy_table_if.slave  bus
);

  logic [NREG-1:0]         busy_q;
  logic [NREG-1:0]         busy_d;
  logic [NREG-1:0][RW-1:0] num_q;
  logic [NREG-1:0][RW-1:0] num_d;

  assign busy_d[0] = 1'b0;
  assign num_d[0]  = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
    logic w0_hit;
    logic w1_hit;
    logic clr_hit;

    assign w0_hit = addr_hit(bus.wen[0], bus.waddr[0], GBT_AW'(gi));
    assign w1_hit = addr_hit(bus.wen[1], bus.waddr[1], GBT_AW'(gi));

    assign clr_hit = busy_q[gi]
                  && ((addr_hit(bus.cmt_en[0], bus.cmt_addr[0], GBT_AW'(gi)) && (bus.cmt_num[0] == num_q[gi]))
                   || (addr_hit(bus.cmt_en[1], bus.cmt_addr[1], GBT_AW'(gi)) && (bus.cmt_num[1] == num_q[gi])));

    // flush > rename (port1 > port0) > commit clear > hold
    assign busy_d[gi] = ~bus.flush & (w0_hit | w1_hit | (busy_q[gi] & ~clr_hit));

    // Flush leaves producer numbers alone; only busy matters afterwards.
    assign num_d[gi] = bus.flush ? num_q[gi]
                     : w1_hit    ? bus.wnum[1]
                     : w0_hit    ? bus.wnum[0]
                     :             num_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= '0;
      num_q  <= '0;
    end else begin
      busy_q <= busy_d;
      num_q  <= num_d;
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar gk = 0; gk < GBT_NRD; gk++) begin : g_rd
    gpr_busy_rdport #(
      .NREG (NREG),
      .RW   (RW)
    ) u_rdport (
      .raddr_i    (bus.raddr[gk]),
      .busy_i     (busy_q),
      .num_i      (num_q),
      .cmt_en_i   (bus.cmt_en),
      .cmt_addr_i (bus.cmt_addr),
      .cmt_num_i  (bus.cmt_num),
      .rbusy_o    (bus.rbusy[gk]),
      .rnum_o     (bus.rnum[gk])
    );
  end

endmodule

// File: tb/tb_gpr_busy_table.sv
// Directed vector bench for gpr_busy_table: one row per cycle, comb reads
// checked before the edge, busy_vec showing the state left by earlier rows.
module tb_gpr_busy_table;
  import gpr_busy_table_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gpr_busy_table_if bus ();

  gpr_busy_table dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  // w/c entries are {en, addr[4:0], num[4:0]}
  typedef struct {
    logic [3:0][4:0]  ra;
    logic [1:0][10:0] w;
    logic [1:0][10:0] c;
    logic             fl;
    logic [3:0]       rb;
    logic [3:0][4:0]  rn;
    logic [31:0]      bv;
  } vec_t;

  vec_t vecs[$];

  localparam logic [10:0] NOP = 11'd0;

  function automatic logic [10:0] P(input logic [4:0] a, input logic [4:0] n);
    return {1'b1, a, n};
  endfunction

  function automatic vec_t mk(input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3,
                              input logic [10:0] w0, input logic [10:0] w1,
                              input logic [10:0] c0, input logic [10:0] c1,
                              input logic fl, input logic [3:0] rb,
                              input logic [4:0] n0, input logic [4:0] n1,
                              input logic [4:0] n2, input logic [4:0] n3,
                              input logic [31:0] bv);
    vec_t v;
    v.ra = {a3, a2, a1, a0};
    v.w  = {w1, w0};
    v.c  = {c1, c0};
    v.fl = fl;
    v.rb = rb;
    v.rn = {n3, n2, n1, n0};
    v.bv = bv;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.raddr = v.ra;
    for (int k = 0; k < 2; k++) begin
      bus.wen[k]      = v.w[k][10];
      bus.waddr[k]    = v.w[k][9:5];
      bus.wnum[k]     = v.w[k][4:0];
      bus.cmt_en[k]   = v.c[k][10];
      bus.cmt_addr[k] = v.c[k][9:5];
      bus.cmt_num[k]  = v.c[k][4:0];
    end
    bus.flush = v.fl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] rb,
                            input logic [3:0][4:0] rn, input logic [31:0] bv);
    check({tag, " rbusy"}, 32'(bus.rbusy), 32'(rb));
    for (int k = 0; k < 4; k++)
      check($sformatf("%s rnum%0d", tag, k), 32'(bus.rnum[k]), 32'(rn[k]));
    check({tag, " busy_vec"}, bus.busy_vec, bv);
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0,0, NOP,NOP, NOP,NOP, 1'b0, 4'b0000, 0,0,0,0, 32'h0);

    // reset state
    vecs.push_back(mk(1,2,3,0,  NOP,NOP,                      NOP,NOP,                      1'b0, 4'b0000, 5'h00,5'h00,5'h00,5'h00, 32'h0000_0000));
    // rename write r5
    vecs.push_back(mk(5,0,0,0,  P(5,5'h03),NOP,               NOP,NOP,                      1'b0, 4'b0000, 5'h00,5'h00,5'h00,5'h00, 32'h0000_0000));
    // r5 visible; both rename ports hit r7, port1 must win
    vecs.push_back(mk(5,0,0,0,  P(7,5'h04),P(7,5'h14),        NOP,NOP,                      1'b0, 4'b0001, 5'h03,5'h00,5'h00,5'h00, 32'h0000_0020));
    // r7 holds port1's number; mismatching commit on r5 leaves it busy
    vecs.push_back(mk(7,5,0,0,  NOP,NOP,                      P(5,5'h13),NOP,               1'b0, 4'b0011, 5'h14,5'h03,5'h00,5'h00, 32'h0000_00A0));
    // matching commit on r5: bypassed to not-busy this cycle
    vecs.push_back(mk(5,7,0,0,  NOP,NOP,                      P(5,5'h03),NOP,               1'b0, 4'b0010, 5'h03,5'h14,5'h00,5'h00, 32'h0000_00A0));
    // r5 cleared, number retained; set up r9
    vecs.push_back(mk(5,7,0,0,  P(9,5'h05),NOP,               NOP,NOP,                      1'b0, 4'b0010, 5'h03,5'h14,5'h00,5'h00, 32'h0000_0080));
    // r9 retires while renamed again in the same cycle
    vecs.push_back(mk(9,0,0,0,  NOP,P(9,5'h16),               NOP,P(9,5'h05),               1'b0, 4'b0000, 5'h05,5'h00,5'h00,5'h00, 32'h0000_0280));
    // rename wins; both commit ports on r7, only port1 matches
    vecs.push_back(mk(9,7,0,0,  NOP,NOP,                      P(7,5'h03),P(7,5'h14),        1'b0, 4'b0001, 5'h16,5'h14,5'h00,5'h00, 32'h0000_0280));
    // r7 cleared; rename r3 and r8
    vecs.push_back(mk(9,7,0,0,  P(3,5'h01),P(8,5'h02),        NOP,NOP,                      1'b0, 4'b0001, 5'h16,5'h14,5'h00,5'h00, 32'h0000_0200));
    // rename r31 and r0 (r0 ignored)
    vecs.push_back(mk(3,8,0,9,  P(31,5'h1F),P(0,5'h0A),       NOP,NOP,                      1'b0, 4'b1011, 5'h01,5'h02,5'h00,5'h16, 32'h0000_0308));
    // flush together with a rename of r4 and a commit on r3
    vecs.push_back(mk(31,0,3,9, P(4,5'h07),NOP,               P(3,5'h01),NOP,               1'b1, 4'b1001, 5'h1F,5'h00,5'h01,5'h16, 32'h8000_0308));
    // everything idle after flush; r4 number never written
    vecs.push_back(mk(4,31,3,9, NOP,NOP,                      NOP,NOP,                      1'b0, 4'b0000, 5'h00,5'h1F,5'h01,5'h16, 32'h0000_0000));
    // rename on r0 only
    vecs.push_back(mk(0,0,0,0,  P(0,5'h05),NOP,               NOP,NOP,                      1'b0, 4'b0000, 5'h00,5'h00,5'h00,5'h00, 32'h0000_0000));
    vecs.push_back(mk(0,4,0,0,  NOP,NOP,                      NOP,NOP,                      1'b0, 4'b0000, 5'h00,5'h00,5'h00,5'h00, 32'h0000_0000));

    drive(idle);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      check_outs($sformatf("row%0d", i), vecs[i].rb, vecs[i].rn, vecs[i].bv);
      @(posedge clk);
      #1;
    end

    // mid-operation reset discards entries, including a same-cycle rename
    drive(mk(0,0,0,0, P(10,5'h0B),NOP, NOP,NOP, 1'b0, 4'b0000, 0,0,0,0, 32'h0));
    @(posedge clk);
    #1;
    drive(idle);
    #1 check("midrst pre busy_vec", bus.busy_vec, 32'h0000_0400);
    drive(mk(0,0,0,0, P(11,5'h0C),NOP, NOP,NOP, 1'b0, 4'b0000, 0,0,0,0, 32'h0));
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(mk(10,11,0,0, NOP,NOP, NOP,NOP, 1'b0, 4'b0000, 0,0,0,0, 32'h0));
    #1 check_outs("midrst post", 4'b0000, {5'h00,5'h00,5'h00,5'h00}, 32'h0);

    // rename right after a flush takes effect normally
    drive(mk(0,0,0,0, NOP,NOP, NOP,NOP, 1'b1, 4'b0000, 0,0,0,0, 32'h0));
    @(posedge clk);
    #1 drive(mk(12,0,0,0, P(12,5'h11),NOP, NOP,NOP, 1'b0, 4'b0000, 0,0,0,0, 32'h0));
    @(posedge clk);
    #1 drive(mk(12,0,0,0, NOP,NOP, NOP,NOP, 1'b0, 4'b0000, 0,0,0,0, 32'h0));
    #1 check_outs("postflush", 4'b0001, {5'h00,5'h00,5'h00,5'h11}, 32'h0000_1000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
